// File: rtl/hpi_pkg.sv
// Shared HPI register selects, controller state encoding and helpers.
// Imported by hpi_xfer_ctrl and its bench.
package hpi_pkg;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    TAIL,
    GAP
  } hpi_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hpi_xfer_ctrl.sv
// Single-word HPI transaction sequencer: req in, timed cs/r/w strobes out,
// read data captured into rsp_rdata, rsp_valid pulse on completion.
// Ports: Clk, Reset_N (sync, low), req_* / rsp_* bus side, busy,
// hpi_address/data_out/r/w/cs out, hpi_data_in in.
// Optional macro HPI_MEMOP_EN: req_mem runs an address write, a one-cycle
// cs-high gap, then the data access to HPI_DATA.
module hpi_xfer_ctrl
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int RD_LAT     = 2
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_mem,
  input  logic [15:0] req_maddr,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  output logic        hpi_r,
  output logic        hpi_w,
  output logic        hpi_cs,
  input  logic [15:0] hpi_data_in
);

  // Reads stay in TAIL until the delayed data has arrived.
  localparam int TAIL_RD = imax(HOLD_CYC, RD_LAT);
  // Counter value on the TAIL cycle with index RD_LAT-1.
  localparam int CAP_IDX = TAIL_RD - RD_LAT;

  hpi_state_t  state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic        cur_wr;
  logic [1:0]  cur_addr;
  logic [15:0] cur_data;
  logic        accept, last, done, capture;

`ifdef HPI_MEMOP_EN
  logic        mphase;
  logic        pend_wr;
  logic [15:0] pend_wdata;
`else
  logic        unused_memop;
  assign unused_memop = ^{req_mem, req_maddr};
`endif

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign accept       = req_valid && req_ready;
  assign last         = (cnt == 8'd0);
  assign hpi_address  = cur_addr;
  assign hpi_data_out = cur_data;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hpi_cs  = 1'b1;
    hpi_r   = 1'b1;
    hpi_w   = 1'b1;
    done    = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = 8'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        hpi_cs = 1'b0;
        if (last) begin
          state_d = STROBE;
          cnt_d   = 8'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      STROBE: begin
        hpi_cs = 1'b0;
        hpi_r  = cur_wr;
        hpi_w  = !cur_wr;
        if (last) begin
          state_d = TAIL;
          cnt_d   = cur_wr ? 8'(HOLD_CYC - 1)
                           : 8'(TAIL_RD - 1);
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      TAIL: begin
        hpi_cs  = 1'b0;
        capture = !cur_wr && (cnt == 8'(CAP_IDX));
        if (last) begin
`ifdef HPI_MEMOP_EN
          if (mphase) begin
            state_d = GAP;
            cnt_d   = 8'd0;
          end else begin
            state_d = IDLE;
            done    = 1'b1;
          end
`else
          state_d = IDLE;
          done    = 1'b1;
`endif
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
`ifdef HPI_MEMOP_EN
      GAP: begin
        state_d = SETUP;
        cnt_d   = 8'(SETUP_CYC - 1);
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      cur_wr    <= 1'b0;
      cur_addr  <= 2'd0;
      cur_data  <= 16'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'd0;
`ifdef HPI_MEMOP_EN
      mphase     <= 1'b0;
      pend_wr    <= 1'b0;
      pend_wdata <= 16'd0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rsp_valid <= done;
      if (capture) rsp_rdata <= hpi_data_in;
      if (accept) begin
`ifdef HPI_MEMOP_EN
        // First leg writes the chip address; the
        // real access is parked until the gap.
        pend_wr    <= req_write;
        pend_wdata <= req_wdata;
        mphase     <= req_mem;
        if (req_mem) begin
          cur_wr   <= 1'b1;
          cur_addr <= HPI_ADDR;
          cur_data <= req_maddr;
        end else begin
          cur_wr   <= req_write;
          cur_addr <= req_addr;
          cur_data <= req_wdata;
        end
`else
        cur_wr   <= req_write;
        cur_addr <= req_addr;
        cur_data <= req_wdata;
`endif
      end
`ifdef HPI_MEMOP_EN
      if (state == GAP) begin
        mphase   <= 1'b0;
        cur_wr   <= pend_wr;
        cur_addr <= HPI_DATA;
        cur_data <= pend_wdata;
      end
`endif
    end
  end

endmodule
